instruction_fetch_ctrl: RTL and testbench
=========================================

# instruction_fetch_ctrl

Sequencer for the instruction memory. Owns the program counter, drives the memory's 8-bit `instruction_address`, captures `instruction_data` into a small prefetch FIFO, and hands instructions to decode over a valid/ready handshake. It also handles branch redirects (flush plus PC reload), halt/resume, and out-of-range fetch faults. It sits between `instruction_mem` and the decode stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, PC and memory address width
- `DATA_WIDTH`, 8, instruction width
- `MEM_DEPTH`, 6, number of valid memory words; addresses >= MEM_DEPTH are out of range
- `FIFO_DEPTH`, 2, prefetch entries (power of two, >= 2)
- `RESET_PC`, 8'h00, PC value after reset

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  single-cycle pulse: begin or resume fetching
- `halt`  in  1  stop issuing new fetches
- `instruction_address`  out  ADDR_WIDTH  to instruction_mem, driven directly from PC
- `instruction_data`  in  DATA_WIDTH  from instruction_mem; combinational, valid in the same cycle as the address
- `instr_valid`  out  1  FIFO head valid
- `instr_data`  out  DATA_WIDTH  FIFO head instruction
- `instr_pc`  out  ADDR_WIDTH  address of the FIFO head
- `instr_ready`  in  1  decode accepts the head
- `redirect_valid`  in  1  branch taken
- `redirect_addr`  in  ADDR_WIDTH  branch target
- `busy`  out  1  state is FETCH
- `fault`  out  1  sticky out-of-range flag
- `fault_addr`  out  ADDR_WIDTH  PC that faulted

## Operation
- States:
  - IDLE: after reset.
  - FETCH: issuing fetches.
  - HALTED: halt taken; FIFO drains.
  - FAULT: terminal until reset.
- Transitions:
  - IDLE/HALTED → FETCH on `start`.
  - FETCH → HALTED on `halt`.
  - FETCH → FAULT when a push is due and PC >= MEM_DEPTH.
  - `start` in FETCH or FAULT is ignored.
- Per-cycle priority in FETCH: redirect > halt > fault check > push.
- Push rule:
  - In FETCH, with no redirect or halt, and with room (count < FIFO_DEPTH, or a pop occurs in the same cycle), write {PC, `instruction_data`} at the FIFO tail and set PC <= PC+1.
  - PC wraps modulo 2^ADDR_WIDTH.
- Pop: `instr_valid && instr_ready`. `instr_*` always reflect the FIFO head.
- Redirect (any state except FAULT):
  - A pop in the same cycle completes normally.
  - All remaining entries are flushed, including any push due that cycle.
  - PC <= `redirect_addr`.
  - State is unchanged (IDLE and HALTED stay put).
  - `instr_valid` is 0 in the next cycle.
- Halt:
  - The cycle with `halt` asserted makes no push.
  - Entries already in the FIFO remain and can still be popped.
  - `start` resumes from the current PC.
  - `halt` and `start` together in HALTED: `start` is ignored; state stays HALTED.
- Fault:
  - On entry, `fault` = 1 and `fault_addr` = PC; no push.
  - Entries already queued still drain.
  - Redirect, start and halt are ignored; only reset clears FAULT.
- `busy` = (state == FETCH).

## Timing
- On reset (`reset_n` low at a clock edge):
  - state = IDLE, PC = RESET_PC, so `instruction_address` = RESET_PC.
  - FIFO empty; `instr_valid`=0, `instr_data`=0, `instr_pc`=0.
  - `busy`=0, `fault`=0, `fault_addr`=0.
- A reset mid-operation discards the FIFO contents and any pending redirect.
- Latency from `start` to first `instr_valid`:
  - Cycle N: `start` sampled.
  - Cycle N+1: FETCH, first push.
  - Cycle N+2: `instr_valid`=1.
- Throughput: one instruction per cycle while `instr_ready` is held high.
- With `instr_ready` held low, the FIFO fills after FIFO_DEPTH pushes and PC holds; the address is re-read on the first cycle that has room.
- Redirect latency: target is on `instruction_address` at cycle R+1; first target instruction is valid at R+2.
- All outputs are registered state, except `instruction_address`, which is the PC register itself.

## Test plan
Memory preloaded with {0A,1B,2C,3D,4E,5F}; defaults unless stated.

- **Reset/start:** release reset, pulse `start`, hold `instr_ready`=1.
  - `instr_valid` rises 2 cycles after `start`.
  - Sequence is (pc,data) = (0,0A),(1,1B)…(5,5F).
  - `fault`=1, `fault_addr`=6 one cycle after PC reaches 6; state FAULT.
- **Backpressure:** `instr_ready`=0 for 5 cycles after start.
  - FIFO holds (0,0A),(1,1B); `instruction_address` stays at 2.
  - On release, 2C follows 1B with no gaps or duplicates.
- **Redirect:** with the FIFO holding (1,1B),(2,2C), assert `redirect_valid`, `redirect_addr`=4, `instr_ready`=1.
  - 1B is consumed in that cycle; 2C is flushed.
  - `instr_valid`=0 the next cycle, then (4,4E),(5,5F).
- **Halt/resume:** assert `halt` at PC=3.
  - FIFO drains; `busy`=0; PC holds at 3.
  - `start` resumes at (3,3D).
  - `halt`+`start` together in HALTED: state stays HALTED.
- **Fault stickiness:** after a fault, apply `redirect_valid` with `redirect_addr`=0 and pulse `start`.
  - No effect; `fault` stays 1.
  - Pulsing `reset_n` low for one cycle clears everything to reset values.
- **Reset mid-stream:** assert reset with 2 entries queued.
  - Next cycle: `instr_valid`=0, `instruction_address`=RESET_PC, state IDLE.

Source files
------------

// File: rtl/instruction_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_ctrl
// Brief    : Instruction memory sequencer. Owns the PC, drives the memory
//            address, prefetches words into a small FIFO and presents them
//            to decode over valid/ready. Handles branch redirects,
//            halt/resume and out-of-range fetch faults.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MEM_DEPTH  = 6,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  busy,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cnt_w-1:0]    c_fifo_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_mem_limit = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_fetch  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;
    localparam logic [1:0] c_st_fault  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_fault_addr;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic       w_pop;
    logic       w_redirect;
    logic       w_room;
    logic       w_push;
    logic       w_fault_hit;
    logic [1:0] w_state_nxt;

    // Per-cycle decisions: redirect beats halt, halt beats the range check,
    // and the range check only matters when a push would otherwise happen.
    always_comb begin
        w_pop       = (r_count != '0) && instr_ready;
        w_redirect  = redirect_valid && (r_state != c_st_fault);
        w_room      = (r_count < c_fifo_full) || w_pop;
        w_push      = 1'b0;
        w_fault_hit = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_redirect && start) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (w_redirect) begin
                    w_state_nxt = c_st_fetch;
                end else if (halt) begin
                    w_state_nxt = c_st_halted;
                end else if (w_room) begin
                    if (r_pc >= c_mem_limit) begin
                        w_fault_hit = 1'b1;
                        w_state_nxt = c_st_fault;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            c_st_halted: begin
                // halt together with start keeps us parked
                if (!w_redirect && start && !halt) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                w_state_nxt = c_st_fault;
            end
        endcase
    end

    // State, program counter and sticky fault capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_pc         <= RESET_PC;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_pc <= redirect_addr;
            end else if (w_push) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_fault_hit) begin
                r_fault      <= 1'b1;
                r_fault_addr <= r_pc;
            end
        end
    end

    // Prefetch FIFO: a redirect drops every entry (the same-cycle pop has
    // already been accepted by decode, so nothing is lost).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= instruction_data;
                r_fifo_pc[r_wr_ptr]   <= r_pc;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign instruction_address = r_pc;
    assign instr_valid         = (r_count != '0);
    assign instr_data          = r_fifo_data[r_rd_ptr];
    assign instr_pc            = r_fifo_pc[r_rd_ptr];
    assign busy                = (r_state == c_st_fetch);
    assign fault               = r_fault;
    assign fault_addr          = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_ctrl
// Brief    : Directed bench for instruction_fetch_ctrl with a 6-word memory
//            model {0A,1B,2C,3D,4E,5F}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       halt;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       busy;
    logic       fault;
    logic [7:0] fault_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .MEM_DEPTH  (6),
        .FIFO_DEPTH (2),
        .RESET_PC   (8'h00)
    ) u_dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .halt                (halt),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .instr_valid         (instr_valid),
        .instr_data          (instr_data),
        .instr_pc            (instr_pc),
        .instr_ready         (instr_ready),
        .redirect_valid      (redirect_valid),
        .redirect_addr       (redirect_addr),
        .busy                (busy),
        .fault               (fault),
        .fault_addr          (fault_addr)
    );

    // Memory model: words 0..5 hold 0A,1B,..,5F; out of range reads EE.
    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        if (a < 8'd6) return (a * 8'h11) + 8'h0A;
        return 8'hEE;
    endfunction

    assign instruction_data = mem_rd(instruction_address);

    typedef struct {
        logic       start;
        logic       halt;
        logic       ready;
        logic       rv;
        logic [7:0] ra;
        logic       e_valid;
        logic [7:0] e_data;
        logic [7:0] e_pc;
        logic [7:0] e_addr;
        logic       e_busy;
        logic       e_fault;
        logic [7:0] e_faddr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] d, input logic [7:0] p);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, instr_data}, {24'd0, d});
        chk({tag, "_pc"}, {24'd0, instr_pc}, {24'd0, p});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_data"}, {24'd0, instr_data}, 32'd0);
        chk({tag, "_pc"}, {24'd0, instr_pc}, 32'd0);
        chk({tag, "_addr"}, {24'd0, instruction_address}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_faddr"}, {24'd0, fault_addr}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        // start, halt, ready, rv, ra | valid, data, pc, addr, busy, fault, faddr
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0A, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h1B, 8'h01, 8'h02, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h2C, 8'h02, 8'h03, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3D, 8'h03, 8'h04, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h4E, 8'h04, 8'h05, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5F, 8'h05, 8'h06, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1, 8'h06};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1, 8'h06};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1, 8'h06};

        // Reset state
        instr_ready = 1'b1;
        do_reset();
        reset_n = 1'b0;
        step();
        chk_reset_state("reset");
        reset_n = 1'b1;

        // Start, full run to fault, then sticky fault
        for (int i = 0; i < 10; i++) begin
            start          = vecs[i].start;
            halt           = vecs[i].halt;
            instr_ready    = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_addr  = vecs[i].ra;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_data", i), {24'd0, instr_data}, {24'd0, vecs[i].e_data});
                chk($sformatf("vec%0d_pc", i), {24'd0, instr_pc}, {24'd0, vecs[i].e_pc});
            end
            chk($sformatf("vec%0d_addr", i), {24'd0, instruction_address}, {24'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].e_fault});
            chk($sformatf("vec%0d_faddr", i), {24'd0, fault_addr}, {24'd0, vecs[i].e_faddr});
        end
        start          = 1'b0;
        redirect_valid = 1'b0;

        // One-cycle reset clears the fault
        reset_n = 1'b0;
        step();
        chk_reset_state("fault_clear");
        reset_n = 1'b1;
        step();
        chk("fault_clear_idle_busy", {31'd0, busy}, 32'd0);
        chk("fault_clear_idle_valid", {31'd0, instr_valid}, 32'd0);

        // Backpressure: ready low for the start cycle and 4 more
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        chk("bp_addr_hold", {24'd0, instruction_address}, 32'd2);
        chk_head("bp_head0", 8'h0A, 8'h00);
        instr_ready = 1'b1;
        step();
        chk_head("bp_head1", 8'h1B, 8'h01);
        chk("bp_addr3", {24'd0, instruction_address}, 32'd3);
        step();
        chk_head("bp_head2", 8'h2C, 8'h02);
        step();
        chk_head("bp_head3", 8'h3D, 8'h03);

        // Redirect with (1,1B),(2,2C) queued
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        instr_ready = 1'b1;
        step();
        chk_head("rd_pre", 8'h1B, 8'h01);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h04;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid_gap", {31'd0, instr_valid}, 32'd0);
        chk("rd_addr", {24'd0, instruction_address}, 32'd4);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        step();
        chk_head("rd_t0", 8'h4E, 8'h04);
        step();
        chk_head("rd_t1", 8'h5F, 8'h05);

        // Halt at PC=3, drain, halt+start, resume
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("ht_pc3", {24'd0, instruction_address}, 32'd3);
        halt = 1'b1;
        instr_ready = 1'b0;
        step();
        chk("ht_busy", {31'd0, busy}, 32'd0);
        chk("ht_addr", {24'd0, instruction_address}, 32'd3);
        chk_head("ht_queued", 8'h2C, 8'h02);
        halt = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("ht_drained", {31'd0, instr_valid}, 32'd0);
        chk("ht_addr_hold", {24'd0, instruction_address}, 32'd3);
        halt = 1'b1;
        start = 1'b1;
        step();
        chk("ht_both_busy", {31'd0, busy}, 32'd0);
        chk("ht_both_addr", {24'd0, instruction_address}, 32'd3);
        halt = 1'b0;
        step();
        start = 1'b0;
        chk("ht_resume_busy", {31'd0, busy}, 32'd1);
        chk("ht_resume_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk_head("ht_resume_head", 8'h3D, 8'h03);
        chk("ht_resume_addr", {24'd0, instruction_address}, 32'd4);

        // Reset mid-stream with two entries queued
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_head("mr_queued", 8'h0A, 8'h00);
        reset_n = 1'b0;
        step();
        chk_reset_state("mr_reset");
        reset_n = 1'b1;
        step();
        chk("mr_idle_busy", {31'd0, busy}, 32'd0);
        chk("mr_idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_idle_addr", {24'd0, instruction_address}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
